lcd_cmd_seq: RTL and testbench
==============================

# lcd_cmd_seq

Command sequencer that sits directly upstream of the LCD image controller and drives its `cmd`/`cmd_valid` port. It fetches packed command words from a small command ROM, expands their repeat counts, and issues each opcode under the controller's `busy` handshake. After issuing a terminal opcode it waits for the controller's `done`. A watchdog and an end-of-ROM check report hung or malformed programs.

## Interface
- `CMD_AW`, 5: command ROM address width; the ROM holds 2^CMD_AW entries.
- `TIMEOUT`, 1023: maximum consecutive cycles spent waiting on `busy` low or `done` high before an error is raised.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sequencing; sampled only in IDLE.
- `cmd_rom_rd`  out  1  ROM read strobe.
- `cmd_rom_a`  out  CMD_AW  ROM address.
- `cmd_rom_q`  in  8  ROM data, valid the cycle after `cmd_rom_rd`. Bits [3:0] are the opcode; bits [7:4] are the repeat field.
- `cmd`  out  4  opcode to the controller.
- `cmd_valid`  out  1  one-cycle issue pulse.
- `busy`  in  1  controller busy; may depend combinationally on `cmd_valid`.
- `done`  in  1  controller finished.
- `seq_busy`  out  1  high from leaving IDLE until FINISH or ERROR.
- `seq_done`  out  1  sticky; high in FINISH.
- `err`  out  1  sticky; high in ERROR.
- `err_code`  out  2  0 = none, 1 = timeout, 2 = no terminal opcode found.
- `issued_cnt`  out  8  number of `cmd_valid` pulses, saturating at 255.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Terminal opcodes:** 0 (write-out) and 12–15. For terminal opcodes the repeat field is ignored and the opcode is issued exactly once. A non-terminal opcode is issued repeat+1 times (1–16).
- **IDLE:** on `start`=1, clear the address to 0 and go to FETCH.
- **FETCH:** assert `cmd_rom_rd`=1 with `cmd_rom_a` set to the current address. Go to LATCH.
- **LATCH:** register the opcode and the repeat count, clear the watchdog, then go to WAIT.
- **WAIT:**
  - If `busy`=0 is sampled at the edge, go to ISSUE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, go to ERROR with `err_code`=1.
- **ISSUE:** drive `cmd_valid`=1 for exactly one cycle with `cmd` set to the opcode, and increment `issued_cnt`. `cmd` keeps its last value afterwards. Go to GUARD.
- **GUARD:** `busy` is ignored in this cycle. Exactly one of the following applies:
  - Repeat count remaining is greater than 0: decrement it, clear the watchdog, go to WAIT.
  - Opcode is terminal: clear the watchdog, go to WAIT_DONE.
  - Address is the last ROM entry (2^CMD_AW−1): go to ERROR with `err_code`=2.
  - Otherwise: increment the address and go to FETCH.
- **WAIT_DONE:**
  - If `done`=1, go to FINISH.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, go to ERROR with `err_code`=1.
- **FINISH / ERROR:** absorbing states; only `reset` leaves them. `start` is ignored.
- **Watchdog width:** the counter is wide enough to hold TIMEOUT.
- **Simultaneous events:** `done` rising while in WAIT is ignored. The `busy` test takes priority over the timeout in the same cycle.

## Timing
- With `start` sampled at edge 0:
  - FETCH is cycle 1.
  - LATCH is cycle 2.
  - WAIT is cycle 3.
  - If `busy`=0 in cycle 3, `cmd_valid`=1 in cycle 4.
- **Back-to-back repeats with `busy` low:** the issue period is 3 cycles (ISSUE, GUARD, WAIT).
- **Next ROM entry:** costs 5 cycles between pulses (ISSUE, GUARD, FETCH, LATCH, WAIT).
- **Output registration:** `seq_done` and `err` rise in the first cycle of FINISH/ERROR. All outputs are registered except `cmd_rom_rd`, which is registered one cycle ahead of LATCH.
- **Reset mid-operation:** outputs return to their reset values immediately, with no `cmd_valid` glitch. A pending repeat is discarded.
- **Watchdog latency:** a hung `busy` produces `err` exactly TIMEOUT+1 cycles after WAIT is entered.

## Test plan
- **Normal program:** ROM {0x31, 0x05, 0x00}; `busy` low except for 1 cycle after each pulse; `done` 70 cycles after the write.
  - Required: pulses with `cmd`=1 ×4, then 5 ×1, then 0 ×1.
  - Required: `issued_cnt`=6, `seq_done`=1, `err`=0.
- **Timeout:** ROM {0x01}; hold `busy`=1.
  - Required: `err`=1 and `err_code`=1 exactly TIMEOUT+1 cycles after WAIT entry.
  - Required: no `cmd_valid` pulse.
- **No terminal opcode:** all 32 entries = 0x02.
  - Required: 32 pulses, then `err_code`=2.
  - Required: `cmd_rom_a` never wraps.
- **Terminal with repeat field:** ROM {0xFF}.
  - Required: a single pulse with `cmd`=15, then WAIT_DONE.
  - With `done` asserted 3 cycles later: `seq_done`=1.
- **Reset mid-repeat:** ROM {0xF3}; assert `reset` after the 5th pulse.
  - Required: all outputs return to 0.
  - Required: after a new `start`, the count restarts and 16 pulses of `cmd`=3 are issued.
- **Saturation and ignored start:** a program that issues more than 255 pulses.
  - Required: `issued_cnt` holds at 255.
  - Required: `start` pulses during FINISH have no effect.

Source files
------------

// File: rtl/lcd_cmd_seq.sv
// Command sequencer feeding the LCD controller: fetches ROM command words, expands repeats,
// issues each opcode under the busy handshake and waits for done after a terminal opcode.
module lcd_cmd_seq #(
    parameter int CMD_AW  = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              cmd_rom_rd,
    output logic [CMD_AW-1:0] cmd_rom_a,
    input  logic [7:0]        cmd_rom_q,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        issued_cnt
);

    localparam int                WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);
    localparam logic [CMD_AW-1:0] LAST_A = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_WAIT, S_ISSUE, S_GUARD, S_WAIT_DONE, S_FINISH, S_ERROR
    } state_t;

    function automatic logic is_term(input logic [3:0] op);
        return (op == 4'd0) || (op >= 4'd12);
    endfunction

    state_t            state_q, state_d;
    logic [CMD_AW-1:0] addr_q, addr_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        rep_q, rep_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              rom_rd_q, rom_rd_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              seq_busy_q, seq_busy_d;
    logic              seq_done_q, seq_done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [7:0]        issued_cnt_q, issued_cnt_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        op_d         = op_q;
        rep_d        = rep_q;
        wd_d         = wd_q;
        err_code_d   = err_code_q;
        cmd_d        = cmd_q;
        issued_cnt_d = issued_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                op_d    = cmd_rom_q[3:0];
                rep_d   = is_term(cmd_rom_q[3:0]) ? 4'd0 : cmd_rom_q[7:4];
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // busy check wins over an expiring watchdog
                if (!busy) begin
                    state_d = S_ISSUE;
                end else if (wd_q == WD_MAX) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: begin
                if (rep_q != 4'd0) begin
                    rep_d   = rep_q - 1'b1;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end else if (is_term(op_q)) begin
                    wd_d    = '0;
                    state_d = S_WAIT_DONE;
                end else if (addr_q == LAST_A) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd2;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_d = S_FINISH;
                end else if (wd_q == WD_MAX) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = state_q;
        endcase

        // Outputs are decoded from the next state so they are flop outputs in the matching cycle
        rom_rd_d    = (state_d == S_FETCH);
        cmd_valid_d = (state_d == S_ISSUE);
        if (state_d == S_ISSUE) begin
            cmd_d = op_q;
            if (issued_cnt_q != 8'hFF) issued_cnt_d = issued_cnt_q + 1'b1;
        end
        seq_busy_d = !(state_d inside {S_IDLE, S_FINISH, S_ERROR});
        seq_done_d = (state_d == S_FINISH);
        err_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            op_q         <= '0;
            rep_q        <= '0;
            wd_q         <= '0;
            rom_rd_q     <= 1'b0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            seq_busy_q   <= 1'b0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            rep_q        <= rep_d;
            wd_q         <= wd_d;
            rom_rd_q     <= rom_rd_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            seq_busy_q   <= seq_busy_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign cmd_rom_rd = rom_rd_q;
    assign cmd_rom_a  = addr_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign seq_busy   = seq_busy_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: ROM and controller models, pulse monitor, hand-computed expectations.
module tb_lcd_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cmd_rom_rd;
    logic [4:0] cmd_rom_a;
    logic [7:0] cmd_rom_q;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       seq_busy, seq_done, err;
    logic [1:0] err_code;
    logic [7:0] issued_cnt;

    lcd_cmd_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_rom_rd(cmd_rom_rd), .cmd_rom_a(cmd_rom_a), .cmd_rom_q(cmd_rom_q),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
        .seq_busy(seq_busy), .seq_done(seq_done), .err(err),
        .err_code(err_code), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:31];
    logic       hold_busy = 1'b0;
    logic       after_pulse;
    int         done_delay = 0;
    int         done_timer;
    int         cyc = 0;

    always @(posedge clk) begin
        if (cmd_rom_rd) cmd_rom_q <= rom[cmd_rom_a];
        cyc = cyc + 1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            after_pulse <= 1'b0;
            done_timer  <= 0;
        end else begin
            after_pulse <= cmd_valid;
            if (cmd_valid && (cmd == 4'd0 || cmd >= 4'd12) && done_delay > 0)
                done_timer <= done_delay;
            else if (done_timer > 0)
                done_timer <= done_timer - 1;
        end
    end

    assign busy = hold_busy | after_pulse;
    assign done = (done_timer == 1);

    // Monitor: cumulative logs of issue pulses and ROM reads
    logic [3:0] p_cmd [0:1023];
    int         p_cyc [0:1023];
    int         n_pulse = 0;
    logic [4:0] rd_a  [0:255];
    int         n_rd = 0;

    always @(negedge clk) begin
        if (cmd_valid) begin
            p_cmd[n_pulse] = cmd;
            p_cyc[n_pulse] = cyc;
            n_pulse = n_pulse + 1;
        end
        if (cmd_rom_rd) begin
            rd_a[n_rd] = cmd_rom_a;
            n_rd = n_rd + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int t0       = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        hold_busy = 1'b0;
        #1;
        check_eq(tag, {8'd0, cmd_valid, cmd_rom_rd, seq_busy, seq_done, err, err_code,
                       issued_cnt, cmd, cmd_rom_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rom_fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    // start is sampled at edge 0; returns at the negedge of cycle 1
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_final(input string tag, input int budget, output int rel);
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seq_done || err) begin
                rel = cyc - t0 + 1;
                break;
            end
        end
        check_eq({tag, "_reached_end"}, (rel >= 0), 1);
    endtask

    int base, rel, bad;

    initial begin
        rom_fill(8'h00);
        do_reset("reset_state");

        // Normal program: 1 x4, 5 x1, 0 x1
        rom_fill(8'h00);
        rom[0] = 8'h31; rom[1] = 8'h05; rom[2] = 8'h00;
        done_delay = 70;
        base = n_pulse;
        do_start();
        check_eq("c1_rom_rd", cmd_rom_rd, 1);
        check_eq("c1_seq_busy", seq_busy, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("c3_no_valid", cmd_valid, 0);
        @(negedge clk);
        check_eq("c4_valid", cmd_valid, 1);
        wait_final("normal", 400, rel);
        check_eq("normal_finish_cycle", rel, 94);
        settle();
        check_eq("normal_npulse", n_pulse - base, 6);
        begin
            logic [3:0] ec [0:5];
            int         et [0:5];
            ec = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd5, 4'd0};
            et = '{4, 7, 10, 13, 18, 23};
            bad = 0;
            for (int i = 0; i < 6; i++)
                if (p_cmd[base+i] !== ec[i] || (p_cyc[base+i] - t0 + 1) != et[i]) bad++;
            check_eq("normal_pulse_seq", bad, 0);
        end
        check_eq("normal_issued", issued_cnt, 6);
        check_eq("normal_done_err", {seq_done, err, seq_busy}, 3'b100);

        // Timeout with busy stuck high
        do_reset("reset_before_timeout");
        rom_fill(8'h00);
        rom[0] = 8'h01;
        hold_busy = 1'b1;
        base = n_pulse;
        do_start();
        wait_final("timeout", 1200, rel);
        check_eq("timeout_err_cycle", rel, 1027);
        check_eq("timeout_code", {err, err_code}, 3'b101);
        settle();
        check_eq("timeout_no_pulse", n_pulse - base, 0);
        hold_busy = 1'b0;

        // No terminal opcode anywhere
        do_reset("reset_before_noterm");
        rom_fill(8'h02);
        base = n_pulse;
        bad = n_rd;
        do_start();
        wait_final("noterm", 600, rel);
        check_eq("noterm_err_cycle", rel, 161);
        check_eq("noterm_code", {err, err_code, seq_done}, 4'b1100);
        settle();
        check_eq("noterm_npulse", n_pulse - base, 32);
        check_eq("noterm_nreads", n_rd - bad, 32);
        begin
            int wrong = 0;
            for (int i = 0; i < 32; i++) if (rd_a[bad+i] !== 5'(i)) wrong++;
            for (int i = 0; i < 32; i++) if (p_cmd[base+i] !== 4'd2) wrong++;
            check_eq("noterm_addr_no_wrap", wrong, 0);
        end

        // Terminal opcode with repeat field set
        do_reset("reset_before_term");
        rom_fill(8'h00);
        rom[0] = 8'hFF;
        done_delay = 3;
        base = n_pulse;
        do_start();
        repeat (5) @(negedge clk);
        check_eq("term_wait_done", {seq_busy, seq_done}, 2'b10);
        wait_final("term", 100, rel);
        check_eq("term_finish_cycle", rel, 8);
        settle();
        check_eq("term_npulse", n_pulse - base, 1);
        check_eq("term_cmd", p_cmd[base], 15);
        check_eq("term_cmd_held", {seq_done, cmd}, 5'h1F);

        // Reset during a repeat run, then a clean rerun
        do_reset("reset_before_midrep");
        rom_fill(8'h00);
        rom[0] = 8'hF3;
        base = n_pulse;
        do_start();
        for (int i = 0; i < 100 && (n_pulse - base) < 5; i++) settle();
        check_eq("midrep_reached5", n_pulse - base, 5);
        do_reset("midrep_async_reset");
        base = n_pulse;
        do_start();
        wait_final("rerun", 200, rel);
        check_eq("rerun_finish_cycle", rel, 58);
        settle();
        check_eq("rerun_npulse", n_pulse - base, 17);
        bad = 0;
        for (int i = 0; i < 16; i++) if (p_cmd[base+i] !== 4'd3) bad++;
        if (p_cmd[base+16] !== 4'd0) bad++;
        check_eq("rerun_cmds", bad, 0);
        check_eq("rerun_issued", issued_cnt, 17);

        // Saturation: 17 x16 repeats then terminal 0xC
        do_reset("reset_before_sat");
        rom_fill(8'h00);
        for (int i = 0; i < 17; i++) rom[i] = 8'hF1;
        rom[17] = 8'h0C;
        base = n_pulse;
        do_start();
        wait_final("sat", 3000, rel);
        settle();
        check_eq("sat_npulse", n_pulse - base, 273);
        check_eq("sat_issued", issued_cnt, 255);
        base = n_pulse;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        repeat (10) @(negedge clk);
        check_eq("sat_start_ignored", {seq_done, seq_busy, err, cmd_rom_rd, issued_cnt}, {4'b1000, 8'd255});
        settle();
        check_eq("sat_no_new_pulse", n_pulse - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
